// File: rtl/hazard_pkg.sv
// hazard_pkg: default geometry and writer-latency constants for the hazard scoreboard
package hazard_pkg;
  localparam int DEF_REG_W = 5;
  localparam int DEF_NREG = 32;
  localparam int DEF_MAX_LAT = 3;
  localparam int DEF_CNT_W = 16;
  localparam int LAT_ALU = 0;
  localparam int LAT_LOAD = 1;
  localparam int LAT_MUL = DEF_MAX_LAT;
  function automatic int lat_w(input int max_lat);
    return $clog2(max_lat + 1);
  endfunction
endpackage

// File: rtl/hazard_lat_counter.sv
// hazard_lat_counter: per-register countdown until its in-flight result is forwardable
module hazard_lat_counter #(
  parameter int LAT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [LAT_W-1:0] val,
  output logic             busy
);
  logic [LAT_W-1:0] cnt;
  assign busy = |cnt;
  // a fresh load wins over the countdown; otherwise count toward zero and stop there
  always_ff @(posedge clk)
    if (reset) cnt <= '0;
    else if (load) cnt <= val;
    else if (busy) cnt <= cnt - LAT_W'(1);
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage stall unit tracking writer latency per register
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_W = DEF_REG_W,
  parameter int NREG = DEF_NREG,
  parameter int MAX_LAT = DEF_MAX_LAT,
  parameter int CNT_W = DEF_CNT_W,
  parameter int LAT_W = lat_w(MAX_LAT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic             id_is_jump,
  input  logic [REG_W-1:0] id_rs,
  input  logic             id_rs_used,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rt_used,
  input  logic             id_wr_en,
  input  logic [REG_W-1:0] id_wr_reg,
  input  logic [LAT_W-1:0] id_wr_lat,
  input  logic             flush,
  output logic             stall,
  output logic             issue,
  output logic [NREG-1:0]  busy_vec,
  output logic [CNT_W-1:0] stall_cycles
);
  localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(MAX_LAT);
  logic hz_rs, hz_rt, load_en;
  logic [LAT_W-1:0] lat_c;
  assign hz_rs = id_rs_used & (id_rs != '0) & busy_vec[id_rs];
  assign hz_rt = id_rt_used & (id_rt != '0) & busy_vec[id_rt];
  assign stall = id_valid & ~id_is_jump & (hz_rs | hz_rt);
  assign issue = id_valid & ~stall & ~flush;
  assign lat_c = (int'(id_wr_lat) > MAX_LAT) ? LAT_MAX : id_wr_lat;
  assign load_en = issue & id_wr_en & (id_wr_reg != '0) & (lat_c != '0);
  assign busy_vec[0] = 1'b0;
  for (genvar g = 1; g < NREG; g++) begin : g_cnt
    hazard_lat_counter #(.LAT_W(LAT_W)) u_cnt (
      .clk  (clk),
      .reset(reset),
      .load (load_en & (id_wr_reg == REG_W'(g))),
      .val  (lat_c),
      .busy (busy_vec[g])
    );
  end
  // saturating count of stalled cycles
  always_ff @(posedge clk)
    if (reset) stall_cycles <= '0;
    else if (stall & ~&stall_cycles) stall_cycles <= stall_cycles + CNT_W'(1);
endmodule
